// File: rtl/twowire_dtm_apb_bridge_pkg.sv
// rtl/twowire_dtm_apb_bridge_pkg.sv - shared op, state and error-flag encodings for the DTM APB bridge
package twowire_dtm_apb_bridge_pkg;

    typedef enum logic [1:0] {
        OP_SETADDR = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_CLRERR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    localparam int ERR_SLVERR  = 0;
    localparam int ERR_DECODE  = 1;
    localparam int ERR_TIMEOUT = 2;

    // Port-index width taken from the top address bits; a single port needs none.
    function automatic int psel_width(input int nports);
        return (nports <= 1) ? 0 : $clog2(nports);
    endfunction

endpackage

// File: rtl/twowire_dtm_apb_bridge_if.sv
// rtl/twowire_dtm_apb_bridge_if.sv - DTM command/response and multi-port APB3 bundles
interface twowire_dtm_cmd_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              cmd_vld;
    logic              cmd_rdy;
    logic [1:0]        cmd_op;
    logic              cmd_incr;
    logic [W_ADDR-1:0] cmd_addr;
    logic [W_DATA-1:0] cmd_wdata;
    logic              resp_vld;
    logic              resp_rdy;
    logic [W_DATA-1:0] resp_rdata;
    logic              resp_err;
    logic [2:0]        err_status;

    modport master (
        output cmd_vld, cmd_op, cmd_incr, cmd_addr, cmd_wdata, resp_rdy,
        input  cmd_rdy, resp_vld, resp_rdata, resp_err, err_status
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_incr, cmd_addr, cmd_wdata, resp_rdy,
        output cmd_rdy, resp_vld, resp_rdata, resp_err, err_status
    );
endinterface

interface twowire_dtm_apb_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int NPORTS = 1
);
    logic [W_ADDR-1:0]        dst_paddr;
    logic [NPORTS-1:0]        dst_psel;
    logic                     dst_penable;
    logic                     dst_pwrite;
    logic [W_DATA-1:0]        dst_pwdata;
    logic [NPORTS-1:0]        dst_pready;
    logic [NPORTS-1:0]        dst_pslverr;
    logic [NPORTS*W_DATA-1:0] dst_prdata;

    modport master (
        output dst_paddr, dst_psel, dst_penable, dst_pwrite, dst_pwdata,
        input  dst_pready, dst_pslverr, dst_prdata
    );

    modport slave (
        input  dst_paddr, dst_psel, dst_penable, dst_pwrite, dst_pwdata,
        output dst_pready, dst_pslverr, dst_prdata
    );
endinterface

// File: rtl/twowire_dtm_apb_port_sel.sv
// rtl/twowire_dtm_apb_port_sel.sv - per-port pready/pslverr/prdata mux with out-of-range index flag
module twowire_dtm_apb_port_sel #(
    parameter int W_DATA = 32,
    parameter int NPORTS = 1,
    parameter int W_IDX  = 1
) (
    input  logic [W_IDX-1:0]         idx,
    input  logic [NPORTS-1:0]        pready,
    input  logic [NPORTS-1:0]        pslverr,
    input  logic [NPORTS*W_DATA-1:0] prdata,
    output logic                     sel_pready,
    output logic                     sel_pslverr,
    output logic [W_DATA-1:0]        sel_prdata,
    output logic                     idx_bad
);

    always_comb begin
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        sel_prdata  = '0;
        idx_bad     = 1'b1;
        for (int k = 0; k < NPORTS; k++) begin
            if (idx == W_IDX'(k)) begin
                sel_pready  = pready[k];
                sel_pslverr = pslverr[k];
                sel_prdata  = prdata[k*W_DATA +: W_DATA];
                idx_bad     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/twowire_dtm_apb_bridge.sv
// rtl/twowire_dtm_apb_bridge.sv - Two-Wire DTM command to multi-port APB3 master bridge
module twowire_dtm_apb_bridge
    import twowire_dtm_apb_bridge_pkg::*;
#(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int NPORTS  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              dck,
    input  logic              drst,
    twowire_dtm_cmd_if.slave  cmd,
    twowire_dtm_apb_if.master apb
);

    localparam int W_PSEL = psel_width(NPORTS);
    localparam int W_IDX  = (W_PSEL == 0) ? 1 : W_PSEL;
    localparam int W_TO   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int INCR   = W_DATA / 8;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              incr_q, incr_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [2:0]        err_q, err_d;
    logic [W_TO-1:0]   cnt_q, cnt_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic [NPORTS-1:0] psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [W_ADDR-1:0] paddr_q, paddr_d;
    logic [W_DATA-1:0] pwdata_q, pwdata_d;
    logic              resp_vld_q, resp_vld_d;
    logic [W_DATA-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [W_IDX-1:0]  port_idx;
    logic              sel_pready, sel_pslverr, idx_bad;
    logic [W_DATA-1:0] sel_prdata;

    generate
        if (W_PSEL == 0) begin : g_one_port
            assign port_idx = '0;
        end else begin : g_multi_port
            assign port_idx = addr_q[W_ADDR-1 -: W_IDX];
        end
    endgenerate

    twowire_dtm_apb_port_sel #(
        .W_DATA (W_DATA),
        .NPORTS (NPORTS),
        .W_IDX  (W_IDX)
    ) u_port_sel (
        .idx         (port_idx),
        .pready      (apb.dst_pready),
        .pslverr     (apb.dst_pslverr),
        .prdata      (apb.dst_prdata),
        .sel_pready  (sel_pready),
        .sel_pslverr (sel_pslverr),
        .sel_prdata  (sel_prdata),
        .idx_bad     (idx_bad)
    );

    always_ff @(posedge dck) begin
        if (drst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_SETADDR;
            incr_q       <= 1'b0;
            addr_q       <= '0;
            err_q        <= '0;
            cnt_q        <= '0;
            cmd_rdy_q    <= 1'b1;
            psel_q       <= '0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            resp_vld_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            incr_q       <= incr_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            cmd_rdy_q    <= cmd_rdy_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            resp_vld_q   <= resp_vld_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        incr_d       = incr_q;
        addr_d       = addr_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        resp_vld_d   = resp_vld_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_vld && cmd_rdy_q) begin
                    op_d         = op_e'(cmd.cmd_op);
                    incr_d       = cmd.cmd_incr;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    state_d      = ST_RESP;
                    resp_vld_d   = 1'b1;
                    case (op_e'(cmd.cmd_op))
                        OP_SETADDR: addr_d = cmd.cmd_addr;
                        OP_CLRERR:  err_d  = '0;
                        default: begin
                            // Any sticky flag blocks bus traffic until CLRERR.
                            if (err_q != 3'b000) begin
                                resp_err_d = 1'b1;
                            end else if (idx_bad) begin
                                err_d[ERR_DECODE] = 1'b1;
                                resp_err_d        = 1'b1;
                            end else begin
                                state_d    = ST_SETUP;
                                resp_vld_d = 1'b0;
                                psel_d     = NPORTS'(1) << port_idx;
                                paddr_d    = addr_q;
                                pwrite_d   = (op_e'(cmd.cmd_op) == OP_WRITE);
                                pwdata_d   = cmd.cmd_wdata;
                            end
                        end
                    endcase
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (sel_pready) begin
                    psel_d       = '0;
                    penable_d    = 1'b0;
                    resp_vld_d   = 1'b1;
                    resp_err_d   = sel_pslverr;
                    resp_rdata_d = (op_q == OP_READ) ? sel_prdata : '0;
                    if (sel_pslverr) err_d[ERR_SLVERR] = 1'b1;
                    if (incr_q && !sel_pslverr) addr_d = addr_q + W_ADDR'(INCR);
                    state_d      = ST_RESP;
                end else if (TIMEOUT != 0 && cnt_q == W_TO'(TIMEOUT - 1)) begin
                    // Abandon a hung slave mid-access; knowingly breaks APB handshake.
                    psel_d             = '0;
                    penable_d          = 1'b0;
                    resp_vld_d         = 1'b1;
                    resp_err_d         = 1'b1;
                    resp_rdata_d       = '0;
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_RESP;
                end else begin
                    cnt_d = cnt_q + W_TO'(1);
                end
            end
            ST_RESP: begin
                if (cmd.resp_rdy) begin
                    resp_vld_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
        endcase
    end

    assign cmd_rdy_d = (state_d == ST_IDLE);

    assign cmd.cmd_rdy     = cmd_rdy_q;
    assign cmd.resp_vld    = resp_vld_q;
    assign cmd.resp_rdata  = resp_rdata_q;
    assign cmd.resp_err    = resp_err_q;
    assign cmd.err_status  = err_q;
    assign apb.dst_paddr   = paddr_q;
    assign apb.dst_psel    = psel_q;
    assign apb.dst_penable = penable_q;
    assign apb.dst_pwrite  = pwrite_q;
    assign apb.dst_pwdata  = pwdata_q;

endmodule
